seq_ripple_adder: RTL

//   Parametrised multi-cycle ripple-carry adder. Adds two WIDTH-bit operands, CHUNK bits per clock,

---
 rtl/seq_adder_pkg.sv | 20 ++
 rtl/seq_ripple_adder_fa_chunk.sv | 31 +++
 rtl/seq_ripple_adder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ripple-carry adder.
// Imported by seq_ripple_adder and its fa_chunk slice adder.
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int n_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   // The operand must split into whole slices, otherwise the last slice would straddle the MSB.
   function automatic bit cfg_ok(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/seq_ripple_adder_fa_chunk.sv
// Combinational CHUNK-bit ripple of full adders: one slice of the sequential adder.
// Also exposes the carry into the slice's top bit so the caller can form signed overflow.
module fa_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic carry;

   // Walk the carry through the slice bit by bit, snapshotting it just before the top bit.
   always_comb begin
      s        = '0;
      carry    = ci;
      c_msb_in = ci;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) begin
            c_msb_in = carry;
         end
         s[i]  = x[i] ^ y[i] ^ carry;
         carry = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
      end
      co = carry;
   end

endmodule

// File: rtl/seq_ripple_adder.sv
// Multi-cycle ripple-carry adder: adds WIDTH-bit operands CHUNK bits per clock with a start/busy/done handshake.
// Optional macro SEQ_RIPPLE_ADDER_SUB_EN adds a 'sub' input selecting a - b - cin.
module seq_ripple_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SEQ_RIPPLE_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   import seq_adder_pkg::*;

   localparam int N     = n_chunks(WIDTH, CHUNK);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   generate
      if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
         $error("seq_ripple_adder: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   state_t             state_q;
   state_t             state_d;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;

   logic [WIDTH-1:0]   b_in;
   logic               cin_in;
   int                 base;
   logic [CHUNK-1:0]   x_sl;
   logic [CHUNK-1:0]   y_sl;
   logic [CHUNK-1:0]   s_sl;
   logic               co_sl;
   logic               cmsb_sl;
   logic [WIDTH-1:0]   sum_full;

   // Subtraction reuses the adder: a - b - cin == a + ~b + ~cin, folded in before latching.
`ifdef SEQ_RIPPLE_ADDER_SUB_EN
   assign b_in   = sub ? ~b : b;
   assign cin_in = sub ? ~cin : cin;
`else
   assign b_in   = b;
   assign cin_in = cin;
`endif

   // Select the active slice and merge its result into the partially built sum.
   always_comb begin
      base                      = int'(idx_q) * CHUNK;
      x_sl                      = a_q[base +: CHUNK];
      y_sl                      = b_q[base +: CHUNK];
      sum_full                  = res_q;
      sum_full[base +: CHUNK]   = s_sl;
   end

   fa_chunk #(.CHUNK(CHUNK)) u_fa_chunk (
      .x        (x_sl),
      .y        (y_sl),
      .ci       (carry_q),
      .s        (s_sl),
      .co       (co_sl),
      .c_msb_in (cmsb_sl)
   );

   // Next-state logic: start is only looked at in IDLE, so requests during RUN/DONE are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and state registers; visible results only change on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b_in;
                  carry_q <= cin_in;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               res_q   <= sum_full;
               carry_q <= co_sl;
               if (idx_q == LAST_IDX) begin
                  sum_q  <= sum_full;
                  cout_q <= co_sl;
                  ovf_q  <= co_sl ^ cmsb_sl;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
